// File: rtl/branch_defs.sv
// Shared branch definitions: funct3 codes, sequencer state encoding, taken decode.
package branch_defs;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // funct3 values 010 and 011 are not branches
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

  // Taken decision from the equality / less-than flags; illegal codes never take
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic taken;
    taken = 1'b0;
    case (f3)
      F3_BEQ:           taken = eq;
      F3_BNE:           taken = ~eq;
      F3_BLT, F3_BLTU:  taken = lt;
      F3_BGE, F3_BGEU:  taken = ~lt;
      default:          taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_chunk_cmp.sv
// Unsigned equality / less-than compare of one operand chunk.
module branch_chunk_cmp #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/branch_comp_seq.sv
// Multi-cycle branch comparator: MSB-chunk-first compare with optional early exit.
module branch_comp_seq
  import branch_defs::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CHUNK      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            br_eq,
  output logic            br_lt,
  output logic            br_taken,
  output logic            illegal
);

  localparam int unsigned N  = XLEN / CHUNK;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]      f3_q, f3_d;
  logic            eq_acc_q, eq_acc_d, lt_acc_q, lt_acc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            live_q;
  logic            out_valid_d, br_eq_d, br_lt_d, br_taken_d, illegal_d;

  logic [CHUNK-1:0] a_chunk_c, b_chunk_c;
  logic             chunk_eq_c, chunk_lt_c;
  logic             eq_next_c, lt_next_c, accept_c;

  // Current chunk selected by idx
  assign a_chunk_c = CHUNK'(a_q >> (32'(idx_q) * CHUNK));
  assign b_chunk_c = CHUNK'(b_q >> (32'(idx_q) * CHUNK));

  branch_chunk_cmp #(.W(CHUNK)) u_chunk_cmp (
    .a  (a_chunk_c),
    .b  (b_chunk_c),
    .eq (chunk_eq_c),
    .lt (chunk_lt_c)
  );

  // Combinational so it drops inside a flush cycle and while reset is asserted
  assign in_ready = live_q & (state_q == ST_IDLE) & ~flush;
  assign accept_c = in_valid & in_ready;

  // Accumulated flags including the chunk under compare; lt is fixed by the first difference
  assign eq_next_c = eq_acc_q & chunk_eq_c;
  assign lt_next_c = (eq_acc_q & ~chunk_eq_c) ? chunk_lt_c : lt_acc_q;

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    f3_d        = f3_q;
    eq_acc_d    = eq_acc_q;
    lt_acc_d    = lt_acc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid;
    br_eq_d     = br_eq;
    br_lt_d     = br_lt;
    br_taken_d  = br_taken;
    illegal_d   = illegal;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          // Flipping the sign bits turns signed order into unsigned chunk order
          a_d            = a;
          b_d            = b;
          a_d[XLEN-1]    = a[XLEN-1] ^ ~funct3[1];
          b_d[XLEN-1]    = b[XLEN-1] ^ ~funct3[1];
          f3_d           = funct3;
          eq_acc_d       = 1'b1;
          lt_acc_d       = 1'b0;
          idx_d          = IDX_LAST;
          state_d        = ST_RUN;
        end
      end
      ST_RUN: begin
        eq_acc_d = eq_next_c;
        lt_acc_d = lt_next_c;
        if ((EARLY_EXIT && !chunk_eq_c) || (idx_q == '0)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          br_eq_d     = eq_next_c;
          br_lt_d     = lt_next_c;
          illegal_d   = f3_illegal(f3_q);
          br_taken_d  = branch_taken(f3_q, eq_next_c, lt_next_c);
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          idx_d       = '0;
          out_valid_d = 1'b0;
          br_eq_d     = 1'b0;
          br_lt_d     = 1'b0;
          br_taken_d  = 1'b0;
          illegal_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      out_valid_d = 1'b0;
      br_eq_d     = 1'b0;
      br_lt_d     = 1'b0;
      br_taken_d  = 1'b0;
      illegal_d   = 1'b0;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      eq_acc_q  <= 1'b0;
      lt_acc_q  <= 1'b0;
      idx_q     <= '0;
      live_q    <= 1'b0;
      out_valid <= 1'b0;
      br_eq     <= 1'b0;
      br_lt     <= 1'b0;
      br_taken  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f3_q      <= f3_d;
      eq_acc_q  <= eq_acc_d;
      lt_acc_q  <= lt_acc_d;
      idx_q     <= idx_d;
      live_q    <= 1'b1;
      out_valid <= out_valid_d;
      br_eq     <= br_eq_d;
      br_lt     <= br_lt_d;
      br_taken  <= br_taken_d;
      illegal   <= illegal_d;
    end
  end

endmodule
